// File: rtl/ecap5_dwbarb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
`default_nettype none
package ecap5_dwbarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } grant_t;

  localparam logic [31:0] DRAIN_DATA = 32'h0;

endpackage
`default_nettype wire

// File: rtl/ecap5_dwbarb_tracker.sv
// Outstanding-request counter and no-ack watchdog for the arbiter's slave port.
`default_nettype none
module ecap5_dwbarb_tracker
  import ecap5_dwbarb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_grant,
  input  logic accept,
  input  logic slave_ack,
  input  logic drain_ack,
  input  logic clear,
  output logic at_limit,
  output logic empty,
  output logic expired
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  logic [OUT_W-1:0] outstanding;
  logic [WD_W-1:0]  wdog;
  logic             inc;
  logic             dec;
  logic             wd_count;

  assign at_limit = (outstanding == OUT_MAX);
  assign empty    = (outstanding == '0);

  // Slave acks only count while granted; an ack with nothing pending is dropped.
  assign inc      = in_grant & accept & ~at_limit;
  assign dec      = ~empty & ((in_grant & slave_ack) | drain_ack);
  assign wd_count = in_grant & ~empty & ~slave_ack;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      outstanding <= '0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + 1'b1;
    end else if (dec && !inc) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !wd_count) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end

  // Fires on the last silent cycle so the FSM enters DRAIN exactly at the limit.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
      assign expired = wd_count & (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_wdog_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ecap5_dwbarb.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter with fair round-robin
// grant, outstanding-request limiting and a draining watchdog.
`default_nettype none
module ecap5_dwbarb
  import ecap5_dwbarb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i,
  output logic        timeout_o
);

  state_t state;
  grant_t last_grant;

  logic in_grant;
  logic cur_cyc;
  logic release_bus;
  logic accept;
  logic drain_ack;
  logic at_limit;
  logic empty;
  logic expired;

  assign in_grant    = (state == GNT0) || (state == GNT1);
  assign cur_cyc     = (state == GNT0) ? m0_wb_cyc_i : m1_wb_cyc_i;
  assign release_bus = in_grant & ~cur_cyc;
  assign accept      = s_wb_stb_o & ~s_wb_stall_i;
  assign drain_ack   = (state == DRAIN) & ~empty;

  ecap5_dwbarb_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_grant  (in_grant),
    .accept    (accept),
    .slave_ack (s_wb_ack_i),
    .drain_ack (drain_ack),
    .clear     (release_bus),
    .at_limit  (at_limit),
    .empty     (empty),
    .expired   (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= M1;
      timeout_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_grant == M1)) begin
            state      <= GNT0;
            last_grant <= M0;
          end else if (m1_wb_cyc_i) begin
            state      <= GNT1;
            last_grant <= M1;
          end
        end
        GNT0: begin
          // Dropping cyc ends (or aborts) the cycle; a waiting peer takes over directly.
          if (!m0_wb_cyc_i) begin
            if (m1_wb_cyc_i) begin
              state      <= GNT1;
              last_grant <= M1;
            end else begin
              state <= IDLE;
            end
          end else if (expired) begin
            state     <= DRAIN;
            timeout_o <= 1'b1;
          end
        end
        GNT1: begin
          if (!m1_wb_cyc_i) begin
            if (m0_wb_cyc_i) begin
              state      <= GNT0;
              last_grant <= M0;
            end else begin
              state <= IDLE;
            end
          end else if (expired) begin
            state     <= DRAIN;
            timeout_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (empty) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_sel_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_dat_o   = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_dat_o   = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    case (state)
      GNT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_stb_o    = m0_wb_stb_i & ~at_limit;
        s_wb_cyc_o    = m0_wb_cyc_i;
        m0_wb_dat_o   = s_wb_dat_i;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i | at_limit;
      end
      GNT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_stb_o    = m1_wb_stb_i & ~at_limit;
        s_wb_cyc_o    = m1_wb_cyc_i;
        m1_wb_dat_o   = s_wb_dat_i;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i | at_limit;
      end
      DRAIN: begin
        // Slave port is idle; the stuck master is retired with dummy acks.
        if (last_grant == M0) begin
          m0_wb_dat_o = DRAIN_DATA;
          m0_wb_ack_o = ~empty;
        end else begin
          m1_wb_dat_o = DRAIN_DATA;
          m1_wb_ack_o = ~empty;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ecap5_dwbarb.sv
// Directed self-checking bench for ecap5_dwbarb (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
`default_nettype none
module tb_ecap5_dwbarb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [31:0] s_dat;
  logic        s_ack, s_stall;
  logic        timeout;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ecap5_dwbarb #(
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m0_wb_adr_i   (m0_adr),
    .m0_wb_dat_i   (m0_dat),
    .m0_wb_sel_i   (m0_sel),
    .m0_wb_we_i    (m0_we),
    .m0_wb_stb_i   (m0_stb),
    .m0_wb_cyc_i   (m0_cyc),
    .m0_wb_dat_o   (m0_dat_o),
    .m0_wb_ack_o   (m0_ack_o),
    .m0_wb_stall_o (m0_stall_o),
    .m1_wb_adr_i   (m1_adr),
    .m1_wb_dat_i   (m1_dat),
    .m1_wb_sel_i   (m1_sel),
    .m1_wb_we_i    (m1_we),
    .m1_wb_stb_i   (m1_stb),
    .m1_wb_cyc_i   (m1_cyc),
    .m1_wb_dat_o   (m1_dat_o),
    .m1_wb_ack_o   (m1_ack_o),
    .m1_wb_stall_o (m1_stall_o),
    .s_wb_adr_o    (s_adr_o),
    .s_wb_dat_o    (s_dat_o),
    .s_wb_sel_o    (s_sel_o),
    .s_wb_we_o     (s_we_o),
    .s_wb_stb_o    (s_stb_o),
    .s_wb_cyc_o    (s_cyc_o),
    .s_wb_dat_i    (s_dat),
    .s_wb_ack_i    (s_ack),
    .s_wb_stall_i  (s_stall),
    .timeout_o     (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Return just after the active edge; inputs are driven here, outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int w;
    int acks;
    bit found;
    logic cur;

    rst = 1'b1;
    m0_adr = 32'h0000_00A0; m0_dat = 32'h1111_0000; m0_sel = 4'hF; m0_we = 1'b0;
    m1_adr = 32'h0000_00B0; m1_dat = 32'h2222_0000; m1_sel = 4'h3; m1_we = 1'b1;
    m0_stb = 1'b0; m0_cyc = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat = 32'h0; s_ack = 1'b0; s_stall = 1'b0;
    tick(); tick();
    #1;
    check_eq("rst_m0_stall", m0_stall_o, 1);
    check_eq("rst_m1_stall", m1_stall_o, 1);
    check_eq("rst_s_cyc", s_cyc_o, 0);
    check_eq("rst_timeout", timeout, 0);

    // 1: single master read with a one-cycle slave ack
    rst = 1'b0;
    m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    check_eq("t1_arb_stall", m0_stall_o, 1);
    check_eq("t1_arb_s_cyc", s_cyc_o, 0);
    tick(); #1;
    check_eq("t1_s_adr", s_adr_o, 32'h0000_0100);
    check_eq("t1_s_sel", s_sel_o, 4'hF);
    check_eq("t1_s_we", s_we_o, 0);
    check_eq("t1_s_stb", s_stb_o, 1);
    check_eq("t1_m0_stall", m0_stall_o, 0);
    check_eq("t1_m1_stall", m1_stall_o, 1);
    tick();
    m0_stb = 1'b0; s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1;
    check_eq("t1_m0_ack", m0_ack_o, 1);
    check_eq("t1_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    check_eq("t1_m1_ack", m1_ack_o, 0);
    check_eq("t1_m1_dat", m1_dat_o, 0);
    check_eq("t1_m1_stall2", m1_stall_o, 1);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0;
    tick(); #1;
    check_eq("t1_idle_s_cyc", s_cyc_o, 0);
    check_eq("t1_idle_m0_stall", m0_stall_o, 1);

    // 2: simultaneous requests out of reset, then direct handoff
    m0_adr = 32'h0000_00A0;
    rst = 1'b1;
    tick();
    rst = 1'b0; m0_cyc = 1'b1; m1_cyc = 1'b1;
    #1;
    check_eq("t2_wait_m0", m0_stall_o, 1);
    check_eq("t2_wait_m1", m1_stall_o, 1);
    tick(); #1;
    check_eq("t2_first_grant", s_adr_o, 32'h0000_00A0);
    check_eq("t2_first_m1_stall", m1_stall_o, 1);
    m0_cyc = 1'b0;
    tick(); #1;
    check_eq("t2_handoff_adr", s_adr_o, 32'h0000_00B0);
    check_eq("t2_handoff_we", s_we_o, 1);
    check_eq("t2_handoff_m1_stall", m1_stall_o, 0);
    m1_cyc = 1'b0;
    tick(); #1;
    check_eq("t2_idle_s_cyc", s_cyc_o, 0);

    // 3: both keep re-requesting; grants must alternate on every release
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick(); #1;
    check_eq("t3_tie_grant", s_adr_o, 32'h0000_00A0);
    cur = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur == 1'b0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      tick();
      if (cur == 1'b0) m0_cyc = 1'b1; else m1_cyc = 1'b1;
      #1;
      check_eq($sformatf("t3_alt%0d_adr", i), s_adr_o, cur ? 32'h0000_00A0 : 32'h0000_00B0);
      check_eq($sformatf("t3_alt%0d_wait_stall", i), cur ? m1_stall_o : m0_stall_o, 1);
      cur = ~cur;
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick(); #1;
    check_eq("t3_idle_s_cyc", s_cyc_o, 0);

    // 4: outstanding limit with acks withheld
    m0_cyc = 1'b1; m0_stb = 1'b1; s_stall = 1'b0;
    tick();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (s_stb_o && !s_stall) acc++;
      tick();
    end
    #1;
    check_eq("t4_accepted", acc, 4);
    check_eq("t4_limit_m0_stall", m0_stall_o, 1);
    check_eq("t4_limit_s_stb", s_stb_o, 0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    #1;
    check_eq("t4_after_ack_s_stb", s_stb_o, 1);
    check_eq("t4_after_ack_stall", m0_stall_o, 0);
    tick();
    m0_stb = 1'b0; s_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    s_ack = 1'b0; m0_cyc = 1'b0;
    tick(); #1;
    check_eq("t4_idle_s_cyc", s_cyc_o, 0);

    // 5: watchdog with two requests pending and a silent slave
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    tick();
    w = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      w++;
      if (w == 1) m1_stb = 1'b0;
      #1;
      if (!s_cyc_o) found = 1'b1;
    end
    check_eq("t5_drain_found", found, 1);
    check_eq("t5_drain_cycle", w, 16);
    s_dat = 32'h1234_5678; s_ack = 1'b1;
    #1;
    check_eq("t5_drain_ack", m1_ack_o, 1);
    check_eq("t5_drain_dat", m1_dat_o, 32'h0);
    check_eq("t5_drain_stall", m1_stall_o, 1);
    check_eq("t5_drain_s_stb", s_stb_o, 0);
    check_eq("t5_timeout", timeout, 1);
    m1_cyc = 1'b0;
    acks = int'(m1_ack_o);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      acks += int'(m1_ack_o);
    end
    s_ack = 1'b0;
    #1;
    check_eq("t5_drain_acks", acks, 2);
    check_eq("t5_timeout_sticky", timeout, 1);
    check_eq("t5_idle_s_cyc", s_cyc_o, 0);
    check_eq("t5_idle_m1_stall", m1_stall_o, 1);

    // 6: reset mid-cycle with three pending requests
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick(); tick(); tick(); tick();
    m1_stb = 1'b0;
    #1;
    check_eq("t6_pre_outstanding", dut.u_tracker.outstanding, 3);
    rst = 1'b1;
    tick(); #1;
    check_eq("t6_rst_m1_stall", m1_stall_o, 1);
    check_eq("t6_rst_m1_ack", m1_ack_o, 0);
    check_eq("t6_rst_s_cyc", s_cyc_o, 0);
    check_eq("t6_rst_s_stb", s_stb_o, 0);
    check_eq("t6_rst_timeout", timeout, 0);
    check_eq("t6_rst_outstanding", dut.u_tracker.outstanding, 0);
    check_eq("t6_rst_wdog", dut.u_tracker.wdog, 0);
    rst = 1'b0; m1_stb = 1'b1;
    tick(); #1;
    check_eq("t6_regrant_s_cyc", s_cyc_o, 1);
    check_eq("t6_regrant_s_stb", s_stb_o, 1);
    check_eq("t6_regrant_m1_stall", m1_stall_o, 0);
    check_eq("t6_regrant_m0_stall", m0_stall_o, 1);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
